ineq_window_filter: RTL and testbench

Parametrised, clocked successor to the combinational inequality classifier. Each valid sample is compared against a programmable lower/upper threshold window and classified one-hot as below, inside or above. Before it reaches the output, the classification passes a persistence filter: a new class takes effect only after FILTER consecutive valid samples agree. It sits between a sampled sensor/count source and control logic that must not react to single-sample glitches.

---
 rtl/ineq_pkg.sv | 29 ++
 rtl/ineq_persist.sv | 75 +++++++
 rtl/ineq_window_filter.sv | 107 ++++++++++
 tb/tb_ineq_window_filter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ineq_pkg.sv
// ineq_pkg: shared definitions for the inequality window filter.
//   class_t      - one-hot class: [2]=above, [1]=inside, [0]=below
//   CLASS_*      - the three legal class codes
//   classify()   - unsigned window compare against inclusive lo/hi bounds
package ineq_pkg;

    typedef logic [2:0] class_t;

    localparam class_t CLASS_BELOW  = 3'b001;
    localparam class_t CLASS_INSIDE = 3'b010;
    localparam class_t CLASS_ABOVE  = 3'b100;

    // Widest operand classify() accepts. Callers zero-extend their WIDTH-bit
    // values to this width; for unsigned operands zero-extension preserves
    // ordering, so the result is exactly the WIDTH-bit comparison.
    localparam int CLS_MAX_W = 64;

    function automatic class_t classify(input logic [CLS_MAX_W-1:0] num,
                                        input logic [CLS_MAX_W-1:0] lo,
                                        input logic [CLS_MAX_W-1:0] hi);
        if (num < lo)
            return CLASS_BELOW;
        else if (num > hi)
            return CLASS_ABOVE;
        else
            return CLASS_INSIDE;
    endfunction

endpackage

// File: rtl/ineq_persist.sv
// ineq_persist: persistence filter for one-hot classes.
// A new class replaces the committed one only after FILTER consecutive
// valid samples agree on it.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   clear        - drop candidate and count (committed class is kept)
//   raw_valid    - raw carries a valid class this cycle
//   raw          - one-hot raw class
//   committed    - registered committed class
//   commit_evt   - combinational: committed changes at the coming edge
//   commit_cls   - combinational: class being committed when commit_evt=1
module ineq_persist
    import ineq_pkg::*;
#(
    parameter int FILTER = 3,
    parameter int CNT_W  = $clog2(FILTER + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       raw_valid,
    input  logic [2:0] raw,
    output logic [2:0] committed,
    output logic       commit_evt,
    output logic [2:0] commit_cls
);

    localparam logic [CNT_W-1:0] FILT_C = CNT_W'(FILTER);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    class_t           comm_q, cand_q, comm_n, cand_n, cand_eff;
    logic [CNT_W-1:0] cnt_q, cnt_n, cnt_eff;

    always_comb begin
        // A clear in the same cycle as a valid raw class acts first, so the
        // sample updates a freshly cleared filter.
        cand_eff   = clear ? CLASS_INSIDE : cand_q;
        cnt_eff    = clear ? '0 : cnt_q;
        cand_n     = cand_eff;
        cnt_n      = cnt_eff;
        comm_n     = comm_q;
        commit_evt = 1'b0;
        if (raw_valid) begin
            if (raw == comm_q) begin
                cnt_n = '0;
            end else if (raw == cand_eff) begin
                cnt_n = (cnt_eff == FILT_C) ? cnt_eff : cnt_eff + ONE_C;
            end else begin
                cand_n = raw;
                cnt_n  = ONE_C;
            end
            if (cnt_n == FILT_C) begin
                comm_n     = cand_n;
                cnt_n      = '0;
                commit_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            comm_q <= CLASS_INSIDE;
            cand_q <= CLASS_INSIDE;
            cnt_q  <= '0;
        end else begin
            comm_q <= comm_n;
            cand_q <= cand_n;
            cnt_q  <= cnt_n;
        end
    end

    assign committed  = comm_q;
    assign commit_cls = comm_n;

endmodule

// File: rtl/ineq_window_filter.sv
// ineq_window_filter: clocked window classifier with persistence filter.
// Each valid sample is classified below/inside/above a programmable
// [lo_q, hi_q] window (inclusive), then filtered so a new class commits
// only after FILTER consecutive agreeing samples. Latency: a sample
// sampled at edge t gives out_valid at edge t+1 (two register stages).
// Optional feature macro: INEQ_STICKY_EN adds sticky_clr / sticky.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   in_valid    - num is a valid sample
//   num         - sample value (unsigned, WIDTH bits)
//   cfg_load    - load lo/hi (rejected when lo > hi)
//   lo, hi      - threshold inputs, inclusive inside bounds
//   out_valid   - one-cycle pulse per accepted sample
//   out         - committed one-hot class
//   cfg_err     - last cfg_load was rejected
//   sticky_clr  - (INEQ_STICKY_EN) clear sticky flags
//   sticky      - (INEQ_STICKY_EN) classes committed since last clear
module ineq_window_filter
    import ineq_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int FILTER = 3,
    localparam int CNT_W  = $clog2(FILTER + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] num,
    input  logic             cfg_load,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
`ifdef INEQ_STICKY_EN
    input  logic             sticky_clr,
    output logic [2:0]       sticky,
`endif
    output logic             out_valid,
    output logic [2:0]       out,
    output logic             cfg_err
);

    logic [WIDTH-1:0]     lo_q, hi_q;
    logic                 v1;
    class_t               raw1;
    logic                 commit_evt;
    class_t               commit_cls;
    logic [CLS_MAX_W-1:0] num_x, lo_x, hi_x;

    assign num_x = CLS_MAX_W'(num);
    assign lo_x  = CLS_MAX_W'(lo_q);
    assign hi_x  = CLS_MAX_W'(hi_q);

    // Stage 1 samples against lo_q/hi_q as they stand before this edge, so a
    // simultaneous cfg_load only affects later samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q      <= '0;
            hi_q      <= '1;
            cfg_err   <= 1'b0;
            v1        <= 1'b0;
            raw1      <= CLASS_INSIDE;
            out_valid <= 1'b0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid)
                raw1 <= classify(num_x, lo_x, hi_x);
            if (cfg_load) begin
                if (lo <= hi) begin
                    lo_q    <= lo;
                    hi_q    <= hi;
                    cfg_err <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    ineq_persist #(
        .FILTER (FILTER),
        .CNT_W  (CNT_W)
    ) u_persist (
        .clk        (clk),
        .reset      (reset),
        .clear      (cfg_load),
        .raw_valid  (v1),
        .raw        (raw1),
        .committed  (out),
        .commit_evt (commit_evt),
        .commit_cls (commit_cls)
    );

`ifdef INEQ_STICKY_EN
    // Set beats clear per bit so a commit coinciding with sticky_clr is kept.
    always_ff @(posedge clk) begin
        if (reset)
            sticky <= 3'b000;
        else
            sticky <= (sticky_clr ? 3'b000 : sticky) |
                      (commit_evt ? commit_cls : 3'b000);
    end
`else
    logic unused_commit;
    assign unused_commit = commit_evt ^ (^commit_cls);
`endif

endmodule

// File: tb/tb_ineq_window_filter.sv
// tb_ineq_window_filter: self-checking bench for ineq_window_filter.
// Handshake: out_valid is a one-cycle pulse, no backpressure; every sample
// accepted with in_valid (outside reset) yields exactly one pulse, sampled
// here on the falling edge.
// The driver updates a cycle-level reference model and pushes the expected
// {cycle, sticky, cfg_err, out} of each sample into exp_q; the monitor pops
// on every out_valid pulse.
module tb_ineq_window_filter;

    localparam int WIDTH  = 4;
    localparam int FILTER = 3;
    localparam int EW     = 39;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] num;
    logic             cfg_load;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             sticky_clr;
    logic [2:0]       sticky;
    logic             out_valid;
    logic [2:0]       out;
    logic             cfg_err;

    ineq_window_filter #(.WIDTH(WIDTH), .FILTER(FILTER)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .num        (num),
        .cfg_load   (cfg_load),
        .lo         (lo),
        .hi         (hi),
`ifdef INEQ_STICKY_EN
        .sticky_clr (sticky_clr),
        .sticky     (sticky),
`endif
        .out_valid  (out_valid),
        .out        (out),
        .cfg_err    (cfg_err)
    );

`ifndef INEQ_STICKY_EN
    assign sticky = 3'b000;
`endif

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_lo, m_hi;
    logic       m_err;
    logic [2:0] m_comm;
    logic [2:0] m_sticky;
    logic [2:0] hist[$];   // agreeing run of raw classes toward a new commit
    logic       p_valid;
    logic [2:0] p_raw;

    function automatic logic [2:0] m_class(input int n, input int l, input int h);
        if (n < l) return 3'b001;
        if (n > h) return 3'b100;
        return 3'b010;
    endfunction

    task automatic model_reset();
        m_lo = 0; m_hi = (1 << WIDTH) - 1; m_err = 1'b0;
        m_comm = 3'b010; m_sticky = 3'b000;
        hist.delete(); p_valid = 1'b0; p_raw = 3'b010;
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic v, input int n, input logic cfg,
                        input int l, input int h, input logic clr, input logic rst);
        logic [2:0] new_raw, commit_bits;
        @(posedge clk); #1;
        in_valid = v; num = WIDTH'(n); cfg_load = cfg;
        lo = WIDTH'(l); hi = WIDTH'(h); sticky_clr = clr; reset = rst;
        if (rst) begin
            model_reset();
        end else begin
            commit_bits = 3'b000;
            new_raw = m_class(n, m_lo, m_hi);
            if (cfg) hist.delete();
            if (p_valid) begin
                if (p_raw == m_comm) begin
                    hist.delete();
                end else begin
                    if (hist.size() > 0 && hist[$] != p_raw) hist.delete();
                    hist.push_back(p_raw);
                    if (hist.size() == FILTER) begin
                        m_comm = p_raw;
                        commit_bits = p_raw;
                        hist.delete();
                    end
                end
            end
            if (cfg) begin
                if (l <= h) begin m_lo = l; m_hi = h; m_err = 1'b0; end
                else m_err = 1'b1;
            end
`ifdef INEQ_STICKY_EN
            m_sticky = (clr ? 3'b000 : m_sticky) | commit_bits;
`endif
            if (p_valid) exp_q.push_back({32'(cyc + 1), m_sticky, m_err, m_comm});
            p_valid = v;
            p_raw   = new_raw;
        end
    endtask

    task automatic sample(input int n);
        step(1'b1, n, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask
    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask
    task automatic load(input int l, input int h);
        step(1'b0, 0, 1'b1, l, h, 1'b0, 1'b0);
    endtask
    task automatic do_reset(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0 && int'(exp_q[0][38:7]) < cyc) begin
            e = exp_q.pop_front();
            chk("missing_pulse_cycle", cyc, int'(e[38:7]));
        end
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, int'(e[38:7]));
                chk("out", int'(out), int'(e[2:0]));
                chk("cfg_err", int'(cfg_err), int'(e[3]));
`ifdef INEQ_STICKY_EN
                chk("sticky", int'(sticky), int'(e[6:4]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; in_valid = 1'b0; num = '0; cfg_load = 1'b0;
        lo = '0; hi = '0; sticky_clr = 1'b0;
        model_reset();
        do_reset(3);
        @(negedge clk);
        chk("reset_out", int'(out), 2);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_cfg_err", int'(cfg_err), 0);
        chk("reset_sticky", int'(sticky), 0);
        idle(5);
        @(negedge clk);
        chk("idle_out", int'(out), 2);

        // 10,10,10 commits above on the third pulse
        load(4, 9);
        sample(10); sample(10); sample(10); idle(3);
        @(negedge clk);
        chk("above_commit", int'(out), 4);

        // alternating run never commits; fresh 3,3,3 commits below
        do_reset(1); load(4, 9);
        sample(10); sample(3); sample(10); sample(3); idle(2);
        @(negedge clk);
        chk("alternate_hold", int'(out), 2);
        load(4, 9);
        sample(3); sample(3); sample(3); idle(2);
        @(negedge clk);
        chk("below_commit", int'(out), 1);

        // rejected load keeps thresholds; 10 still above
        load(9, 4); idle(1);
        @(negedge clk);
        chk("cfg_reject", int'(cfg_err), 1);
        sample(10); sample(10); sample(10); idle(2);
        @(negedge clk);
        chk("old_thresholds", int'(out), 4);
        load(2, 12); idle(1);
        @(negedge clk);
        chk("cfg_accept", int'(cfg_err), 0);

        // commit to below with sticky_clr on the commit edge, then gapped input
        load(4, 9);
        sample(3); sample(3); sample(3);
        step(1'b0, 0, 1'b0, 0, 0, 1'b1, 1'b0);
        idle(1);
        sample(10); idle(2); sample(10); idle(1); sample(10); idle(2);
        @(negedge clk);
        chk("gapped_commit", int'(out), 4);

        // reset drops the filter history: two 10s, reset, one 10
        do_reset(1); load(4, 9);
        sample(10); sample(10); do_reset(1); sample(10); idle(3);
        @(negedge clk);
        chk("reset_mid_run", int'(out), 2);

        // single-value window and boundaries
        load(7, 7);
        for (int i = 0; i < 12; i++) sample((i % 3) + 6);
        idle(2);

        // randomized phase
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0)
                step(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b1);
            else
                step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                     1'($urandom_range(0, 24) == 0),
                     int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                     1'($urandom_range(0, 9) == 0), 1'b0);
        end
        idle(4);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
